bus_memcpy_master: RTL and testbench
====================================

// Module: bus_memcpy_master
// PURPOSE
//  Bus initiator (DMA copy engine) for the req/ack/resp memory bus served by our RAM responders.
//  On start, copies len 32-bit words from src to dst: one read, then one write, per word.
//  Sits between a control register block and one RAM bus port. Only one transaction is outstanding at a time.
// PARAMETERS
//  len_width  16  width of word-count input/counters
//  addr_step  4   byte-address increment per word
// PORTS
//  clk_i          in   1          clock
//  rst_i          in   1          synchronous active-high reset
//  start_i        in   1          start pulse; sampled only in IDLE
//  src_addr_bi    in   32         source byte address (captured at start)
//  dst_addr_bi    in   32         destination byte address (captured at start)
//  len_bi         in   len_width  number of words to copy (captured at start)
//  busy_o         out  1          high in every state except IDLE
//  done_o         out  1          one-cycle pulse when the copy completes
//  words_done_bo  out  len_width  count of words written so far
//  bus_req_o      out  1          bus request
//  bus_we_o       out  1          1 = write, 0 = read
//  bus_addr_bo    out  32         bus byte address
//  bus_be_bo      out  4          byte enables, always 4'hF
//  bus_wdata_bi   n/a  -          (none; see bus_wdata_bo)
//  bus_wdata_bo   out  32         write data
//  bus_ack_i      in   1          request accepted this cycle
//  bus_resp_i     in   1          read data valid
//  bus_rdata_bi   in   32         read data
// BEHAVIOUR
//  Reset: IDLE; busy_o=0, done_o=0, bus_req_o=0, bus_we_o=0.
//   bus_addr_bo=0, bus_wdata_bo=0, words_done_bo=0. bus_be_bo=4'hF (constant).
//  Reset is honoured in any state, mid-transfer included: req drops the next edge and no further bus activity occurs.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> (RD_REQ | DONE) -> IDLE.
//  IDLE:
//   - On start_i: capture src, dst and len; clear words_done_bo.
//   - len != 0 -> RD_REQ; len == 0 -> DONE (no bus cycles).
//  RD_REQ: req=1, we=0, addr=cur_src.
//   - Req and addr are held stable until bus_ack_i.
//   - On ack: cur_src += addr_step (mod 2^32) -> RD_WAIT.
//  RD_WAIT: req=0.
//   - On bus_resp_i: latch bus_rdata_bi into wdata register -> WR_REQ.
//   - resp is only honoured in RD_WAIT; resp in any other state is ignored.
//  WR_REQ: req=1, we=1, addr=cur_dst, wdata=latched word; held until ack.
//   - On ack: cur_dst += addr_step; words_done_bo += 1; remaining -= 1.
//   - remaining becomes 0 -> DONE; else -> RD_REQ.
//  DONE: done_o=1 for exactly one cycle; busy_o=1; -> IDLE.
//  start_i outside IDLE is ignored. Inputs changing after start have no effect.
//  Zero-wait responder (ack = req, resp the cycle after ack): 3 cycles per word.
//   - Start at cycle 0 gives RD_REQ at cycle 1; last WR ack at cycle 3N; done_o at cycle 3N+1.
//  Address counters wrap modulo 2^32 silently. Remaining count is len_width bits.
//   - len_bi = 2^len_width - 1 is the maximum transfer.
// TESTING
//  1. RAM src 0x100..0x10C = A0,A1,A2,A3, start src=0x100 dst=0x200 len=4, zero-wait
//     -> 0x200..0x20C = A0..A3; done_o pulse at cycle 13; words_done_bo=4.
//  2. len=0, start -> done_o at cycle 1, busy_o high cycles 1 only, bus_req_o never asserted.
//  3. ack withheld 3 cycles on each request, len=2
//     -> req/we/addr/wdata stable while waiting; data copied correctly; 2 reads, 2 writes.
//  4. start_i re-pulsed with different src/dst during copy of len=3 -> ignored; original copy completes, one done_o.
//  5. rst_i asserted in RD_WAIT of word 2 of 4 -> next cycle all outputs at reset values.
//     Later start performs a full new copy.
//  6. src=0xFFFFFFFC len=2 -> reads at 0xFFFFFFFC then 0x00000000 (wrap), writes to dst, dst+4.

Source files
------------

// File: rtl/bus_memcpy_master.sv
// DMA copy engine: copies len 32-bit words from src to dst over a req/ack/resp
// memory bus, one read followed by one write per word, one transaction in flight.
module bus_memcpy_master #(
    parameter int unsigned len_width = 16,
    parameter int unsigned addr_step = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_bi,
    input  logic [31:0]          dst_addr_bi,
    input  logic [len_width-1:0] len_bi,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [len_width-1:0] words_done_bo,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [31:0]          bus_addr_bo,
    output logic [3:0]           bus_be_bo,
    output logic [31:0]          bus_wdata_bo,
    input  logic                 bus_ack_i,
    input  logic                 bus_resp_i,
    input  logic [31:0]          bus_rdata_bi
);

    localparam logic [31:0]          step = 32'(addr_step);
    localparam logic [len_width-1:0] one  = len_width'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    state_t               state;
    logic [31:0]          cur_src;
    logic [31:0]          cur_dst;
    logic [len_width-1:0] remaining;

    assign bus_be_bo = 4'hF;

    // Control FSM; every bus-facing output is a register updated on the transition into a state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cur_src       <= '0;
            cur_dst       <= '0;
            remaining     <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            words_done_bo <= '0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_bo   <= '0;
            bus_wdata_bo  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cur_src       <= src_addr_bi;
                        cur_dst       <= dst_addr_bi;
                        remaining     <= len_bi;
                        words_done_bo <= '0;
                        busy_o        <= 1'b1;
                        if (len_bi == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state       <= RD_REQ;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= 1'b0;
                            bus_addr_bo <= src_addr_bi;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus_ack_i) begin
                        cur_src   <= cur_src + step;
                        bus_req_o <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus_resp_i) begin
                        bus_wdata_bo <= bus_rdata_bi;
                        bus_req_o    <= 1'b1;
                        bus_we_o     <= 1'b1;
                        bus_addr_bo  <= cur_dst;
                        state        <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (bus_ack_i) begin
                        cur_dst       <= cur_dst + step;
                        words_done_bo <= words_done_bo + one;
                        remaining     <= remaining - one;
                        bus_we_o      <= 1'b0;
                        // Last word: drop the request; otherwise go straight into the next read.
                        if (remaining == one) begin
                            bus_req_o <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bus_addr_bo <= cur_src;
                            state       <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o    <= 1'b0;
                    bus_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_memcpy_master.sv
// Bench for bus_memcpy_master: behavioural RAM responder with configurable ack/resp
// latency, word-level copy model, and per-scenario checks.
module tb_bus_memcpy_master;

    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_done;
    logic          req;
    logic          we;
    logic [31:0]   addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          ack;
    logic          resp;
    logic [31:0]   rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_memcpy_master #(.len_width(LW), .addr_step(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .src_addr_bi(src), .dst_addr_bi(dst), .len_bi(len),
        .busy_o(busy), .done_o(done), .words_done_bo(words_done),
        .bus_req_o(req), .bus_we_o(we), .bus_addr_bo(addr), .bus_be_bo(be),
        .bus_wdata_bo(wdata), .bus_ack_i(ack), .bus_resp_i(resp), .bus_rdata_bi(rdata)
    );

    // RAM responder model
    logic [31:0] mem [bit [31:0]];
    bit [31:0]   rd_log[$];
    bit [31:0]   wr_addr_log[$];
    bit [31:0]   wr_data_log[$];
    int          ack_cfg  = 0;
    int          resp_cfg = 0;
    bit          rand_mode = 1'b0;
    int          ack_cur  = 0;
    int          wcnt     = 0;
    bit          rd_pend  = 1'b0;
    int          rd_left  = 0;
    logic [31:0] rd_q     = '0;

    assign ack   = req && (wcnt >= ack_cur);
    assign resp  = rd_pend && (rd_left == 0);
    assign rdata = rd_q;

    function automatic logic [31:0] mem_rd(input bit [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            wcnt    <= 0;
            rd_pend <= 1'b0;
            rd_left <= 0;
            ack_cur <= ack_cfg;
        end else begin
            if (req && !ack) wcnt <= wcnt + 1;
            else begin
                wcnt    <= 0;
                ack_cur <= rand_mode ? int'($urandom_range(0, 3)) : ack_cfg;
            end
            if (rd_pend) begin
                if (rd_left == 0) rd_pend <= 1'b0;
                else rd_left <= rd_left - 1;
            end
            if (req && ack) begin
                if (we) begin
                    mem[addr] = wdata;
                    wr_addr_log.push_back(addr);
                    wr_data_log.push_back(wdata);
                end else begin
                    rd_q    <= mem_rd(addr);
                    rd_pend <= 1'b1;
                    rd_left <= rand_mode ? int'($urandom_range(0, 2)) : resp_cfg;
                    rd_log.push_back(addr);
                end
            end
        end
    end

    function automatic void clear_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endfunction

    // Starts a copy and observes it cycle by cycle (cycle 1 = first cycle after the start edge).
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n,
                            input int max_cyc, input int pulse_at,
                            output int done_cyc, output int done_pulses, output int busy_cyc,
                            output int req_cyc, output int unstable);
        logic        p_req, p_ack, p_we;
        logic [31:0] p_addr, p_wdata;
        int          cyc, tail;
        done_cyc = -1; done_pulses = 0; busy_cyc = 0; req_cyc = 0; unstable = 0;
        p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        @(negedge clk);
        src = s; dst = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0; src = $urandom; dst = $urandom; len = LW'($urandom);
        cyc = 1; tail = -1;
        while (cyc <= max_cyc && tail != 0) begin
            if (cyc == pulse_at) begin
                start = 1'b1; src = $urandom; dst = $urandom; len = LW'(5);
            end else start = 1'b0;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
                tail = 3;
            end
            if (busy) busy_cyc++;
            if (req) req_cyc++;
            if (p_req && !p_ack && (!req || we !== p_we || addr !== p_addr || (we && wdata !== p_wdata)))
                unstable++;
            p_req = req; p_ack = ack; p_we = we; p_addr = addr; p_wdata = wdata;
            if (tail > 0) tail--;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
        total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h exp=0", req); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0h exp=0", we); end
        total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", addr); end
        total++; if (wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", wdata); end
        total++; if (words_done !== '0) begin bad++; $display("FAIL reset_words got=%0h exp=0", words_done); end
        total++; if (be !== 4'hF) begin bad++; $display("FAIL reset_be got=%0h exp=f", be); end
        rst = 1'b0;
    endtask

    task automatic test_basic_copy();
        logic [31:0] exp[4];
        int dc, dp, bc, rc, un;
        ack_cfg = 0; resp_cfg = 0; rand_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp[i] = $urandom;
            mem[32'h100 + 32'(4 * i)] = exp[i];
        end
        clear_logs();
        run_copy(32'h100, 32'h200, LW'(4), 200, -1, dc, dp, bc, rc, un);
        total++; if (dc !== 13) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=13", dc); end
        total++; if (dp !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", dp); end
        total++; if (bc !== 13) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=13", bc); end
        total++; if (words_done !== LW'(4)) begin bad++; $display("FAIL basic_words got=%0d exp=4", words_done); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_rd(32'h200 + 32'(4 * i)) !== exp[i]) begin
                bad++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, mem_rd(32'h200 + 32'(4 * i)), exp[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        int dc, dp, bc, rc, un;
        clear_logs();
        run_copy(32'h300, 32'h400, LW'(0), 50, -1, dc, dp, bc, rc, un);
        total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
        total++; if (dp !== 1) begin bad++; $display("FAIL zero_done_pulses got=%0d exp=1", dp); end
        total++; if (bc !== 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=1", bc); end
        total++; if (rc !== 0) begin bad++; $display("FAIL zero_req_cycles got=%0d exp=0", rc); end
        total++; if (words_done !== '0) begin bad++; $display("FAIL zero_words got=%0d exp=0", words_done); end
    endtask

    task automatic test_ack_wait();
        logic [31:0] exp[2];
        int dc, dp, bc, rc, un;
        ack_cfg = 3; resp_cfg = 0; rand_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp[i] = $urandom;
            mem[32'h500 + 32'(4 * i)] = exp[i];
        end
        clear_logs();
        run_copy(32'h500, 32'h600, LW'(2), 200, -1, dc, dp, bc, rc, un);
        // each request waits 3 extra cycles: 4 + 1 + 4 cycles per word
        total++; if (dc !== 19) begin bad++; $display("FAIL wait_done_cycle got=%0d exp=19", dc); end
        total++; if (un !== 0) begin bad++; $display("FAIL wait_unstable got=%0d exp=0", un); end
        total++; if (rd_log.size() !== 2) begin bad++; $display("FAIL wait_reads got=%0d exp=2", rd_log.size()); end
        total++; if (wr_addr_log.size() !== 2) begin bad++; $display("FAIL wait_writes got=%0d exp=2", wr_addr_log.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (mem_rd(32'h600 + 32'(4 * i)) !== exp[i]) begin
                bad++; $display("FAIL wait_data[%0d] got=%0h exp=%0h", i, mem_rd(32'h600 + 32'(4 * i)), exp[i]);
            end
        end
        ack_cfg = 0;
    endtask

    task automatic test_restart_ignored();
        int dc, dp, bc, rc, un;
        clear_logs();
        run_copy(32'h700, 32'h800, LW'(3), 200, 4, dc, dp, bc, rc, un);
        total++; if (dc !== 10) begin bad++; $display("FAIL restart_done_cycle got=%0d exp=10", dc); end
        total++; if (dp !== 1) begin bad++; $display("FAIL restart_done_pulses got=%0d exp=1", dp); end
        total++; if (wr_addr_log.size() !== 3) begin bad++; $display("FAIL restart_writes got=%0d exp=3", wr_addr_log.size()); end
        for (int i = 0; i < wr_addr_log.size() && i < 3; i++) begin
            total++;
            if (wr_addr_log[i] !== 32'h800 + 32'(4 * i)) begin
                bad++; $display("FAIL restart_waddr[%0d] got=%0h exp=%0h", i, wr_addr_log[i], 32'h800 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, dp, bc, rc, un, reqs;
        ack_cfg = 0; resp_cfg = 0; rand_mode = 1'b0;
        clear_logs();
        @(negedge clk);
        src = 32'h900; dst = 32'hA00; len = LW'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        // cycle 5: waiting for the read data of word 2
        total++; if ({busy, req} !== 2'b10) begin bad++; $display("FAIL mid_in_rd_wait got=%0b exp=10", {busy, req}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({busy, done, req, we} !== 4'b0) begin bad++; $display("FAIL mid_rst_ctrl got=%0b exp=0", {busy, done, req, we}); end
        total++; if (addr !== 32'h0 || wdata !== 32'h0) begin bad++; $display("FAIL mid_rst_bus got=%0h/%0h exp=0/0", addr, wdata); end
        total++; if (words_done !== '0) begin bad++; $display("FAIL mid_rst_words got=%0d exp=0", words_done); end
        reqs = 0;
        repeat (8) begin @(negedge clk); if (req) reqs++; end
        total++; if (reqs !== 0) begin bad++; $display("FAIL mid_quiet_req got=%0d exp=0", reqs); end
        total++; if (rd_log.size() !== 2 || wr_addr_log.size() !== 1) begin
            bad++; $display("FAIL mid_bus_counts got=%0d/%0d exp=2/1", rd_log.size(), wr_addr_log.size());
        end
        clear_logs();
        run_copy(32'h900, 32'hB00, LW'(4), 200, -1, dc, dp, bc, rc, un);
        total++; if (dc !== 13 || words_done !== LW'(4)) begin bad++; $display("FAIL mid_recopy got=%0d/%0d exp=13/4", dc, words_done); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem_rd(32'hB00 + 32'(4 * i)) !== mem_rd(32'h900 + 32'(4 * i))) begin
                bad++; $display("FAIL mid_data[%0d] got=%0h exp=%0h", i, mem_rd(32'hB00 + 32'(4 * i)), mem_rd(32'h900 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_rd[2];
        logic [31:0] exp_d[2];
        int dc, dp, bc, rc, un;
        exp_rd[0] = 32'hFFFF_FFFC; exp_rd[1] = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin exp_d[i] = $urandom; mem[exp_rd[i]] = exp_d[i]; end
        clear_logs();
        run_copy(32'hFFFF_FFFC, 32'hC00, LW'(2), 100, -1, dc, dp, bc, rc, un);
        total++; if (rd_log.size() !== 2 || wr_addr_log.size() !== 2) begin
            bad++; $display("FAIL wrap_counts got=%0d/%0d exp=2/2", rd_log.size(), wr_addr_log.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (rd_log[i] !== exp_rd[i] || wr_addr_log[i] !== 32'hC00 + 32'(4 * i) || wr_data_log[i] !== exp_d[i]) begin
                    bad++; $display("FAIL wrap_word[%0d] got=%0h->%0h:%0h exp=%0h->%0h:%0h", i, rd_log[i],
                                    wr_addr_log[i], wr_data_log[i], exp_rd[i], 32'hC00 + 32'(4 * i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] exp[$];
        logic [31:0] s, d;
        int n, dc, dp, bc, rc, un;
        rand_mode = 1'b1;
        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(1, 9));
            s = 32'h0001_0000 + 32'(t * 32'h100) + {20'h0, 6'($urandom), 2'b00};
            d = 32'h0008_0000 + 32'(t * 32'h100) + {20'h0, 6'($urandom), 2'b00};
            exp.delete();
            for (int i = 0; i < n; i++) begin
                mem[s + 32'(4 * i)] = $urandom;
                exp.push_back(mem[s + 32'(4 * i)]);
            end
            clear_logs();
            run_copy(s, d, LW'(n), 500, -1, dc, dp, bc, rc, un);
            total++; if (dp !== 1) begin bad++; $display("FAIL rand%0d_done_pulses got=%0d exp=1", t, dp); end
            total++; if (un !== 0) begin bad++; $display("FAIL rand%0d_unstable got=%0d exp=0", t, un); end
            total++; if (words_done !== LW'(n)) begin bad++; $display("FAIL rand%0d_words got=%0d exp=%0d", t, words_done, n); end
            total++; if (rd_log.size() !== n || wr_addr_log.size() !== n) begin
                bad++; $display("FAIL rand%0d_counts got=%0d/%0d exp=%0d", t, rd_log.size(), wr_addr_log.size(), n);
            end
            for (int i = 0; i < n; i++) begin
                total++;
                if (mem_rd(d + 32'(4 * i)) !== exp[i]) begin
                    bad++; $display("FAIL rand%0d_data[%0d] got=%0h exp=%0h", t, i, mem_rd(d + 32'(4 * i)), exp[i]);
                end
            end
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_ack_wait();
        test_restart_ignored();
        test_reset_mid();
        test_wrap();
        test_random_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
